// File: rtl/mem_io_responder.sv
// CPU-facing byte RAM plus memory-mapped UART/cycle-counter IO; reads return 1 cycle after sampling.
// rdy_in=0 freezes the bus side only; TX drains on tx_ready, io_buffer_full warns one slot early.

module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_vld,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop_rdy,
  output logic                       head_vld,
  output logic [W-1:0]               head_dat,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  store [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign head_vld = (count != '0);
  assign head_dat = store[rd_ptr];
  // A push into a full queue is dropped even if a pop happens on the same edge.
  assign do_push  = push_vld && (count != FULL_CNT);
  assign do_pop   = head_vld && pop_rdy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && do_push) store[wr_ptr] <= push_dat;
  end
endmodule

module mem_io_responder #(
  parameter int RAM_AW    = 17,
  parameter int TXQ_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        program_stop
);
  localparam int CW = $clog2(TXQ_DEPTH) + 1;
  localparam logic [CW-1:0] NEAR_FULL = CW'(TXQ_DEPTH - 1);

  logic [7:0]        ram [2**RAM_AW];
  logic [RAM_AW-1:0] ram_addr;
  logic [15:0]       io_off;
  logic              is_ram;
  logic              is_io;
  logic              bus_rd;
  logic              bus_wr;
  logic              io_wr_ok;
  logic              stop_wr;
  logic              tx_push_vld;
  logic [7:0]        tx_push_dat;
  logic [CW-1:0]     tx_cnt;
  logic [31:0]       cycle_cnt;
  logic [31:0]       snapshot;
  logic [7:0]        io_rd_dat;
  logic [7:0]        ram_q;
  logic [7:0]        io_q;
  logic              src_ram;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^mem_a[31:18];

  assign ram_addr = mem_a[RAM_AW-1:0];
  assign io_off   = mem_a[15:0];
  assign is_ram   = !mem_a[17];
  assign is_io    = (mem_a[17:16] == 2'b11);
  assign bus_rd   = rdy_in && !mem_wr;
  assign bus_wr   = rdy_in && mem_wr;

  // After the stop write every IO write is dead; RAM traffic is unaffected.
  assign io_wr_ok    = bus_wr && is_io && !program_stop;
  assign stop_wr     = io_wr_ok && (io_off == 16'h0004);
  assign tx_push_vld = stop_wr || (io_wr_ok && (io_off == 16'h0000) && (mem_dout != 8'h00));
  assign tx_push_dat = stop_wr ? 8'h00 : mem_dout;

  always_comb begin
    io_rd_dat = 8'h00;
    case (io_off)
      16'h0000: io_rd_dat = rx_valid ? rx_data : 8'h00;
      16'h0004: io_rd_dat = cycle_cnt[7:0];
      16'h0005: io_rd_dat = snapshot[15:8];
      16'h0006: io_rd_dat = snapshot[23:16];
      16'h0007: io_rd_dat = snapshot[31:24];
      default:  io_rd_dat = 8'h00;
    endcase
  end

  // Read-first RAM; the output register is unreset so it maps onto block RAM.
  always_ff @(posedge clk_in) begin
    if (bus_rd) ram_q <= ram[ram_addr];
    if (rst_in && bus_wr && is_ram) ram[ram_addr] <= mem_dout;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      src_ram      <= 1'b0;
      io_q         <= 8'h00;
      rx_pop       <= 1'b0;
      program_stop <= 1'b0;
      cycle_cnt    <= 32'd0;
      snapshot     <= 32'd0;
    end else begin
      rx_pop <= bus_rd && is_io && (io_off == 16'h0000) && rx_valid;
      if (rdy_in) cycle_cnt <= cycle_cnt + 32'd1;
      if (bus_rd) begin
        src_ram <= is_ram;
        io_q    <= is_io ? io_rd_dat : 8'h00;
      end
      if (bus_rd && is_io && (io_off == 16'h0004)) snapshot <= cycle_cnt;
      if (stop_wr) program_stop <= 1'b1;
    end
  end

  assign mem_din = src_ram ? ram_q : io_q;

  sync_fifo #(
    .W     (8),
    .DEPTH (TXQ_DEPTH)
  ) u_txq (
    .clk      (clk_in),
    .rst_n    (rst_in),
    .push_vld (tx_push_vld),
    .push_dat (tx_push_dat),
    .pop_rdy  (tx_ready),
    .head_vld (tx_valid),
    .head_dat (tx_data),
    .count    (tx_cnt)
  );

  assign io_buffer_full = (tx_cnt >= NEAR_FULL);
endmodule

// File: doc/mem_io_responder.md
MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 SHALL have parameter RAM_AW, default 17, meaning RAM address bits (128KB).
REQ-002 SHALL have parameter TXQ_DEPTH, default 8, meaning TX byte FIFO entries (power of two, >=4).
REQ-003 SHALL have one clock; reset SHALL be synchronous and active-low.
REQ-004 Ports, listed as name / direction / width / meaning:
- clk_in / in / 1 / system clock.
- rst_in / in / 1 / synchronous active-low reset.
- rdy_in / in / 1 / bus pause; CPU-side bus ignored while low.
- mem_a / in / 32 / CPU address; only bits 17:0 decoded.
- mem_wr / in / 1 / 1 = write, 0 = read.
- mem_dout / in / 8 / CPU write data.
- mem_din / out / 8 / read data returned to CPU.
- io_buffer_full / out / 1 / TX FIFO near-full back-pressure.
- tx_data / out / 8 / UART TX byte.
- tx_valid / out / 1 / TX byte available.
- tx_ready / in / 1 / UART accepts byte.
- rx_data / in / 8 / UART RX byte.
- rx_valid / in / 1 / RX byte available.
- rx_pop / out / 1 / consume RX byte.
- program_stop / out / 1 / sticky end-of-program flag.

Function
REQ-005 Region decode on mem_a[17:16]: 00/01 = RAM, 10 = unmapped, 11 = IO.
REQ-006 A bus transaction SHALL be sampled on every rising edge with rdy_in=1; with rdy_in=0 no read, write, FIFO push, rx_pop or snapshot occurs, and mem_din holds.
REQ-007 RAM read SHALL return ram[mem_a[RAM_AW-1:0]] on mem_din exactly one cycle after sampling (registered); latency is fixed at 1.
REQ-008 RAM write SHALL update ram[mem_a[RAM_AW-1:0]] with mem_dout at the sampling edge; a read of the same address in the next cycle SHALL return the new byte.
REQ-009 Unmapped region: read returns 0x00 next cycle; write ignored.
REQ-010 IO read 0x30000: mem_din next cycle = rx_data if rx_valid else 0x00; rx_pop pulses 1 for one cycle only when rx_valid=1.
REQ-011 Cycle counter: 32-bit, increments on each cycle with rdy_in=1, wraps 0xFFFFFFFF -> 0.
REQ-012 IO read 0x30004 SHALL latch a counter snapshot and return snapshot[7:0]; reads of 0x30005/6/7 return snapshot bytes 1/2/3 of the latest snapshot without relatching.
REQ-013 Other IO read addresses SHALL return 0x00.
REQ-014 IO write 0x30000 with mem_dout != 0 SHALL push mem_dout into the TX FIFO; mem_dout == 0 SHALL be ignored.
REQ-015 IO write 0x30004 SHALL set program_stop and push 0x00 into the TX FIFO.
REQ-016 Once program_stop=1, all further IO writes SHALL be ignored; RAM access continues.
REQ-017 TX FIFO: tx_valid = not empty; tx_data = head entry; pop on tx_valid && tx_ready, independent of rdy_in.
REQ-018 Simultaneous push and pop SHALL keep count unchanged. Push when count == TXQ_DEPTH SHALL be dropped with the FIFO unchanged. Pointers wrap modulo TXQ_DEPTH.
REQ-019 io_buffer_full SHALL be 1 when count >= TXQ_DEPTH-1, combinational from count, giving one slot of margin for an in-flight write.

Reset
REQ-020 When rst_in=0 at an edge: mem_din=0, rx_pop=0, program_stop=0, counter=0, snapshot=0, FIFO empty (tx_valid=0, io_buffer_full=0); RAM contents are not cleared.
REQ-021 Reset SHALL take priority over any concurrent bus transaction or FIFO pop; a byte presented on tx_data in the reset cycle is discarded.

Verification
REQ-022 Write 0x5A to 0x00100, then read 0x00100 next cycle -> mem_din=0x5A one cycle after the read edge; read 0x20010 -> 0x00.
REQ-023 tx_ready=0; write 0x41, 0x00, 0x42 ... to 0x30000 -> only nonzero bytes queued; io_buffer_full rises when count=7; the 9th push is dropped; raising tx_ready drains 8 bytes in order, 1 per cycle.
REQ-024 Run 100 cycles with rdy_in=1 after reset, read 0x30004..0x30007 -> bytes of snapshot value ~100 (exact per edge count), with bytes 1-3 equal to 0; holding rdy_in=0 for 10 cycles does not advance the counter.
REQ-025 rx_valid=1, rx_data=0x37; read 0x30000 -> mem_din=0x37, rx_pop one-cycle pulse; with rx_valid=0 -> 0x00 and no pulse.
REQ-026 Write to 0x30004 -> program_stop=1 and 0x00 emitted on tx; a later write of 0x41 to 0x30000 is ignored; asserting rst_in=0 mid-drain -> FIFO empty and program_stop=0 at the next edge.
